struct_array_regfile: RTL and testbench

Parametrised register file that stores an array of packed struct entries `{valid, tag, data}`. It supports one write port, one registered read port, a flattened whole-array output and a sequenced fill engine that rewrites every entry with a programmable pattern. It generalises the fixed all-ones 32-bit struct-array constant into a configurable, writable array. The block sits beside simple-test tops as the reusable struct-array storage element.

---
 rtl/struct_array_regfile.sv | 144 ++++++++++++++
 tb/tb_struct_array_regfile.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/struct_array_regfile.sv
// rtl/struct_array_regfile.sv - Writable array of packed {valid, tag, data} entries with registered read and fill sweep
module struct_array_regfile #(
  parameter int                     NUM_ENTRIES = 4,
  parameter int                     TAG_W       = 7,
  parameter int                     DATA_W      = 24,
  parameter logic [TAG_W+DATA_W:0]  RESET_VAL   = '1,
  localparam int                    ENTRY_W     = 1 + TAG_W + DATA_W,
  localparam int                    ADDR_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [ENTRY_W-1:0]               wr_data,
  output logic                             wr_ready,
  input  logic                             rd_en,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [ENTRY_W-1:0]               rd_data,
  output logic                             rd_valid,
  input  logic                             fill_req,
  input  logic [ENTRY_W-1:0]               fill_val,
  output logic                             busy,
  output logic [NUM_ENTRIES*ENTRY_W-1:0]   o
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]                           state;
  logic [ADDR_W-1:0]                    ptr;
  entry_t                               fill_lat;
  entry_t                               entries      [NUM_ENTRIES];
  entry_t                               entries_next [NUM_ENTRIES];
  entry_t                               rd_word;
  logic [NUM_ENTRIES*ENTRY_W-1:0]       flat_next;
  logic                                 wr_fire;
  logic                                 fill_last;

  // Both status flags come straight from the state register, so they never
  // depend combinationally on an input.
  assign busy     = (state == ST_FILL);
  assign wr_ready = (state == ST_IDLE);

  // A fill request in IDLE wins over a same-cycle write, which is dropped.
  assign wr_fire   = wr_en && wr_ready && !fill_req;
  assign fill_last = (ptr == ADDR_W'(NUM_ENTRIES - 1));

  // Next-state array: the fill sweep owns the write path while busy; an
  // address with no matching entry simply matches nothing and is dropped.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entries_next[i] = entries[i];
      if (busy && (ptr == ADDR_W'(i))) begin
        entries_next[i] = fill_lat;
      end else if (wr_fire && (wr_addr == ADDR_W'(i))) begin
        entries_next[i] = entry_t'(wr_data);
      end
    end
  end

  // Read mux over the current (pre-write) contents; unmatched address gives 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = entries[i];
      end
    end
  end

  // Flatten the next-state array with entry 0 in the LSBs.
  always_comb begin
    flat_next = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      flat_next[i*ENTRY_W +: ENTRY_W] = entries_next[i];
    end
  end

  // Storage and its flat mirror commit on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= entry_t'(RESET_VAL);
      end
      o <= {NUM_ENTRIES{RESET_VAL}};
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= entries_next[i];
      end
      o <= flat_next;
    end
  end

  // Registered read port; data holds when no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word;
      end
    end
  end

  // Fill sequencer: latch the pattern, then write one entry per cycle
  // from 0 up to NUM_ENTRIES-1 and fall back to IDLE without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      fill_lat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fill_req) begin
            fill_lat <= entry_t'(fill_val);
            ptr      <= '0;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (fill_last) begin
            ptr   <= '0;
            state <= ST_IDLE;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_struct_array_regfile.sv
// tb/tb_struct_array_regfile.sv - Scoreboard bench for struct_array_regfile at default and small parameters
module tb_struct_array_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          wr_en, wr_ready, rd_en, rd_valid, fill_req, busy;
  logic [1:0]    wr_addr, rd_addr;
  logic [31:0]   wr_data, rd_data, fill_val;
  logic [127:0]  o;

  logic          s_wr_en, s_wr_ready, s_rd_en, s_rd_valid, s_fill_req, s_busy;
  logic [2:0]    s_wr_addr, s_rd_addr;
  logic [7:0]    s_wr_data, s_rd_data, s_fill_val;
  logic [63:0]   s_o;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cnt;
  logic [31:0]   exp_q[$];
  logic [31:0]   mon_exp;

  struct_array_regfile dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .fill_req(fill_req), .fill_val(fill_val), .busy(busy), .o(o)
  );

  struct_array_regfile #(.NUM_ENTRIES(8), .TAG_W(3), .DATA_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .fill_req(s_fill_req), .fill_val(s_fill_val), .busy(s_busy), .o(s_o)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rd_valid consumes one expected read result.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_valid", {127'd0, rd_valid}, 128'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", {96'd0, rd_data}, {96'd0, mon_exp});
      end
    end
  end

  initial begin
    rst = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0; fill_req = 0; fill_val = 0;
    s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_rd_en = 0; s_rd_addr = 0; s_fill_req = 0; s_fill_val = 0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_o", o, {4{32'hFFFF_FFFF}});
    check("reset_rd_valid", {127'd0, rd_valid}, 128'd0);
    check("reset_rd_data", {96'd0, rd_data}, 128'd0);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_wr_ready", {127'd0, wr_ready}, 128'd1);
    check("reset_s_o", {64'd0, s_o}, {64'd0, {8{8'hFF}}});

    wr_en = 1; wr_addr = 2; wr_data = 32'h8012_3456;
    tick();
    wr_en = 0;
    check("write2_o", o, {32'hFFFF_FFFF, 32'h8012_3456, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    rd_en = 1; rd_addr = 2; exp_q.push_back(32'h8012_3456);
    tick();
    rd_en = 0;

    wr_en = 1; wr_addr = 1; wr_data = 32'h0;
    rd_en = 1; rd_addr = 1; exp_q.push_back(32'hFFFF_FFFF);
    tick();
    wr_en = 0;
    rd_addr = 1; exp_q.push_back(32'h0);
    tick();
    rd_en = 0;
    tick();
    check("collision_o", o, {32'hFFFF_FFFF, 32'h8012_3456, 32'h0, 32'hFFFF_FFFF});
    check("idle_rd_valid", {127'd0, rd_valid}, 128'd0);

    fill_req = 1; fill_val = 32'hA5A5_A5A5;
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234_5678;
    tick();
    fill_req = 0;
    check("fill_write_dropped", o, {32'hFFFF_FFFF, 32'h8012_3456, 32'h0, 32'hFFFF_FFFF});
    check("fill_wr_ready_low", {127'd0, wr_ready}, 128'd0);
    wr_addr = 3; wr_data = 32'h0;
    rd_en = 1; rd_addr = 2; exp_q.push_back(32'h8012_3456);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      tick();
      rd_en = 0;
      if (cnt == 1) check("fill_first_entry", {64'd0, o[63:0]}, {64'd0, 32'h0, 32'hA5A5_A5A5});
    end
    wr_en = 0;
    check("fill_busy_cycles", cnt, 4);
    check("fill_wr_ready_back", {127'd0, wr_ready}, 128'd1);
    check("fill_o", o, {4{32'hA5A5_A5A5}});

    fill_req = 1; fill_val = 32'h5A5A_5A5A;
    tick();
    fill_req = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("abort_o", o, {4{32'hFFFF_FFFF}});
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_wr_ready", {127'd0, wr_ready}, 128'd1);

    fill_req = 1; fill_val = 32'h1234_5678;
    tick();
    fill_req = 0;
    check("refill_busy", {127'd0, busy}, 128'd1);
    tick();
    check("refill_ptr_zero", o, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678});
    cnt = 1;
    while (busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check("refill_busy_cycles", cnt, 4);
    check("refill_o", o, {4{32'h1234_5678}});

    fill_req = 1; fill_val = 32'hC3C3_C3C3;
    tick();
    fill_req = 0;
    check("b2b_busy", {127'd0, busy}, 128'd1);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check("b2b_busy_cycles", cnt, 4);
    check("b2b_o", o, {4{32'hC3C3_C3C3}});

    s_wr_en = 1; s_wr_addr = 7; s_wr_data = 8'h3C;
    tick();
    s_wr_en = 0;
    check("s_write7_o", {64'd0, s_o}, {64'd0, 8'h3C, {7{8'hFF}}});
    check("s_entry7_slice", {120'd0, s_o[63:56]}, {120'd0, 8'h3C});
    s_fill_req = 1; s_fill_val = 8'h81;
    tick();
    s_fill_req = 0;
    cnt = 0;
    while (s_busy && cnt < 30) begin
      cnt++;
      tick();
    end
    check("s_fill_busy_cycles", cnt, 8);
    check("s_fill_o", {64'd0, s_o}, {64'd0, {8{8'h81}}});
    s_rd_en = 1; s_rd_addr = 7;
    tick();
    s_rd_en = 0;
    check("s_rd_data", {120'd0, s_rd_data}, {120'd0, 8'h81});
    check("s_rd_valid", {127'd0, s_rd_valid}, 128'd1);

    tick();
    tick();
    check("rd_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
